// File: rtl/score_sequencer.sv
// score_sequencer: rhythm-game note sequencer; loads goal notes, arbitrates hits vs timeouts, commits scores.
// Ports: clk/rst, start/tick/mod/difficulty run control, chart_* goal handshake,
// hit_* key events, sc_* to/from scoring datapath, total_score/max_combo/level_out/busy/done/failed status.
module score_sequencer #(
  parameter int NUM_W       = 27,
  parameter int CLK_W       = 16,
  parameter int NOTE_W      = 4,
  parameter int MISS_WIN    = 188,
  parameter int FAIL_MISSES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              tick,
  input  logic [1:0]        mod,
  input  logic [3:0]        difficulty,
  input  logic              chart_valid,
  output logic              chart_ready,
  input  logic [CLK_W-1:0]  chart_time,
  input  logic [NOTE_W-1:0] chart_note,
  input  logic              chart_last,
  input  logic              hit_valid,
  input  logic [NOTE_W-1:0] hit_note,
  output logic [CLK_W-1:0]  sc_clock,
  output logic [NOTE_W-1:0] sc_note,
  output logic [CLK_W-1:0]  sc_goal_clock,
  output logic [NOTE_W-1:0] sc_goal_note,
  output logic [NUM_W-1:0]  sc_last_combo,
  output logic [NUM_W-1:0]  sc_now_cnt,
  output logic [NUM_W-1:0]  sc_last_base_score,
  input  logic [NUM_W-1:0]  sc_base_score,
  input  logic [NUM_W-1:0]  sc_bonus_score,
  input  logic [NUM_W-1:0]  sc_combo,
  input  logic [2:0]        sc_level,
  output logic [NUM_W-1:0]  total_score,
  output logic [NUM_W-1:0]  max_combo,
  output logic [2:0]        level_out,
  output logic              busy,
  output logic              done,
  output logic              failed
);
  localparam int MS_W  = $clog2(FAIL_MISSES + 1);
  localparam int WIN_W = CLK_W + 2;
  typedef enum logic [2:0] {IDLE, LOAD, ARMED, EVAL, DONE, FAIL} state_t;
  state_t state_q, state_d;
  logic [1:0] mod_q, mod_d;
  logic [3:0] diff_q, diff_d;
  logic last_q, last_d;
  logic [CLK_W-1:0] game_time_q, game_time_d;
  logic [MS_W-1:0] miss_q, miss_d, miss_nxt;
  logic [CLK_W-1:0] sc_clock_q, sc_clock_d, sc_goal_clock_q, sc_goal_clock_d;
  logic [NOTE_W-1:0] sc_note_q, sc_note_d, sc_goal_note_q, sc_goal_note_d;
  logic [NUM_W-1:0] sc_last_combo_q, sc_last_combo_d, sc_now_cnt_q, sc_now_cnt_d;
  logic [NUM_W-1:0] sc_last_base_score_q, sc_last_base_score_d;
  logic [NUM_W-1:0] total_score_q, total_score_d, max_combo_q, max_combo_d;
  logic [2:0] level_q, level_d;
  logic busy_q, busy_d, done_q, done_d, failed_q, failed_d, chart_ready_q, chart_ready_d;
  logic [WIN_W-1:0] win, gt_ext, goal_ext;
  logic [NUM_W:0] base_sum;
  logic [NUM_W+1:0] total_sum;
  logic hit_ok, timeout, miss, fail_now;
  always_comb begin
    win       = WIN_W'(MISS_WIN) - WIN_W'(diff_q) * WIN_W'(3);
    gt_ext    = WIN_W'(game_time_q);
    goal_ext  = WIN_W'(sc_goal_clock_q);
    hit_ok    = hit_valid && (gt_ext + win > goal_ext);
    timeout   = gt_ext >= goal_ext + win;
    base_sum  = {1'b0, sc_last_base_score_q} + {1'b0, sc_base_score};
    total_sum = {2'b0, total_score_q} + {2'b0, sc_base_score} + {2'b0, sc_bonus_score};
    miss      = sc_base_score == '0;
    // streak saturates so No Fail runs with long miss runs never wrap back to zero
    miss_nxt  = !miss ? '0 : (miss_q == MS_W'(FAIL_MISSES)) ? miss_q : miss_q + 1'b1;
    fail_now  = miss && mod_q != 2'b01 && miss_nxt >= MS_W'(FAIL_MISSES);
    state_d              = state_q;
    mod_d                = mod_q;
    diff_d               = diff_q;
    last_d               = last_q;
    miss_d               = miss_q;
    sc_clock_d           = sc_clock_q;
    sc_note_d            = sc_note_q;
    sc_goal_clock_d      = sc_goal_clock_q;
    sc_goal_note_d       = sc_goal_note_q;
    sc_last_combo_d      = sc_last_combo_q;
    sc_now_cnt_d         = sc_now_cnt_q;
    sc_last_base_score_d = sc_last_base_score_q;
    total_score_d        = total_score_q;
    max_combo_d          = max_combo_q;
    level_d              = level_q;
    game_time_d          = (tick && busy_q && game_time_q != '1) ? game_time_q + 1'b1 : game_time_q;
    case (state_q)
      IDLE, DONE, FAIL: if (start) begin
        state_d              = LOAD;
        mod_d                = mod;
        diff_d               = difficulty;
        game_time_d          = '0;
        miss_d               = '0;
        total_score_d        = '0;
        max_combo_d          = '0;
        sc_last_combo_d      = '0;
        sc_now_cnt_d         = '0;
        sc_last_base_score_d = '0;
      end
      LOAD: if (chart_valid) begin
        state_d         = ARMED;
        sc_goal_clock_d = chart_time;
        sc_goal_note_d  = chart_note;
        last_d          = chart_last;
      end
      ARMED: if (hit_ok || timeout) begin
        state_d    = EVAL;
        sc_clock_d = game_time_q;
        // a timeout forces a note mismatch so the datapath scores it as a miss
        sc_note_d  = hit_ok ? hit_note : ~sc_goal_note_q;
      end
      EVAL: begin
        state_d              = fail_now ? FAIL : last_q ? DONE : LOAD;
        miss_d               = miss_nxt;
        sc_last_base_score_d = base_sum[NUM_W] ? '1 : base_sum[NUM_W-1:0];
        total_score_d        = |total_sum[NUM_W+1:NUM_W] ? '1 : total_sum[NUM_W-1:0];
        sc_last_combo_d      = sc_combo;
        max_combo_d          = sc_combo > max_combo_q ? sc_combo : max_combo_q;
        sc_now_cnt_d         = sc_now_cnt_q == '1 ? sc_now_cnt_q : sc_now_cnt_q + 1'b1;
        level_d              = sc_level;
      end
      default: state_d = IDLE;
    endcase
    busy_d        = state_d == LOAD || state_d == ARMED || state_d == EVAL;
    done_d        = state_d == DONE;
    failed_d      = state_d == FAIL;
    chart_ready_d = state_d == LOAD;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= IDLE;
      mod_q                <= '0;
      diff_q               <= '0;
      last_q               <= 1'b0;
      game_time_q          <= '0;
      miss_q               <= '0;
      sc_clock_q           <= '0;
      sc_note_q            <= '0;
      sc_goal_clock_q      <= '0;
      sc_goal_note_q       <= '0;
      sc_last_combo_q      <= '0;
      sc_now_cnt_q         <= '0;
      sc_last_base_score_q <= '0;
      total_score_q        <= '0;
      max_combo_q          <= '0;
      level_q              <= 3'd1;
      busy_q               <= 1'b0;
      done_q               <= 1'b0;
      failed_q             <= 1'b0;
      chart_ready_q        <= 1'b0;
    end else begin
      state_q              <= state_d;
      mod_q                <= mod_d;
      diff_q               <= diff_d;
      last_q               <= last_d;
      game_time_q          <= game_time_d;
      miss_q               <= miss_d;
      sc_clock_q           <= sc_clock_d;
      sc_note_q            <= sc_note_d;
      sc_goal_clock_q      <= sc_goal_clock_d;
      sc_goal_note_q       <= sc_goal_note_d;
      sc_last_combo_q      <= sc_last_combo_d;
      sc_now_cnt_q         <= sc_now_cnt_d;
      sc_last_base_score_q <= sc_last_base_score_d;
      total_score_q        <= total_score_d;
      max_combo_q          <= max_combo_d;
      level_q              <= level_d;
      busy_q               <= busy_d;
      done_q               <= done_d;
      failed_q             <= failed_d;
      chart_ready_q        <= chart_ready_d;
    end
  end
  assign chart_ready        = chart_ready_q;
  assign sc_clock           = sc_clock_q;
  assign sc_note            = sc_note_q;
  assign sc_goal_clock      = sc_goal_clock_q;
  assign sc_goal_note       = sc_goal_note_q;
  assign sc_last_combo      = sc_last_combo_q;
  assign sc_now_cnt         = sc_now_cnt_q;
  assign sc_last_base_score = sc_last_base_score_q;
  assign total_score        = total_score_q;
  assign max_combo          = max_combo_q;
  assign level_out          = level_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign failed             = failed_q;
endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer: directed self-checking bench for score_sequencer.
module tb_score_sequencer;
  localparam int NUM_W = 27, CLK_W = 16, NOTE_W = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, tick = 1'b0;
  logic [1:0] mod = '0;
  logic [3:0] difficulty = '0;
  logic chart_valid = 1'b0, chart_last = 1'b0, hit_valid = 1'b0;
  logic chart_ready;
  logic [CLK_W-1:0] chart_time = '0;
  logic [NOTE_W-1:0] chart_note = '0, hit_note = '0;
  logic [CLK_W-1:0] sc_clock, sc_goal_clock;
  logic [NOTE_W-1:0] sc_note, sc_goal_note;
  logic [NUM_W-1:0] sc_last_combo, sc_now_cnt, sc_last_base_score, total_score, max_combo;
  logic [NUM_W-1:0] sc_base_score = '0, sc_bonus_score = '0, sc_combo = '0;
  logic [2:0] sc_level = 3'd1, level_out;
  logic busy, done, failed;
  int checks = 0, errors = 0;
  score_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .tick(tick), .mod(mod), .difficulty(difficulty),
    .chart_valid(chart_valid), .chart_ready(chart_ready), .chart_time(chart_time),
    .chart_note(chart_note), .chart_last(chart_last), .hit_valid(hit_valid), .hit_note(hit_note),
    .sc_clock(sc_clock), .sc_note(sc_note), .sc_goal_clock(sc_goal_clock), .sc_goal_note(sc_goal_note),
    .sc_last_combo(sc_last_combo), .sc_now_cnt(sc_now_cnt), .sc_last_base_score(sc_last_base_score),
    .sc_base_score(sc_base_score), .sc_bonus_score(sc_bonus_score), .sc_combo(sc_combo),
    .sc_level(sc_level), .total_score(total_score), .max_combo(max_combo), .level_out(level_out),
    .busy(busy), .done(done), .failed(failed)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_start(input logic [1:0] m, input logic [3:0] d);
    mod = m; difficulty = d; start = 1'b1;
    step();
    start = 1'b0;
  endtask
  task automatic load_note(input logic [CLK_W-1:0] t, input logic [NOTE_W-1:0] n, input logic l);
    chart_valid = 1'b1; chart_time = t; chart_note = n; chart_last = l;
    step();
    chart_valid = 1'b0;
  endtask
  task automatic hit(input logic [NOTE_W-1:0] n);
    hit_valid = 1'b1; hit_note = n;
    step();
    hit_valid = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    chk("rst_total", total_score, 0);
    chk("rst_maxcombo", max_combo, 0);
    chk("rst_level", level_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_failed", failed, 0);
    chk("rst_ready", chart_ready, 0);
    chk("rst_cnt", sc_now_cnt, 0);
    chk("rst_clock", sc_clock, 0);
    // single note hit on time
    sc_base_score = 500000; sc_bonus_score = 1000; sc_combo = 2; sc_level = 3'd1;
    run_start(2'b00, 4'd0);
    chk("load_ready", chart_ready, 1);
    chk("load_busy", busy, 1);
    load_note(100, 5, 1'b1);
    chk("armed_ready", chart_ready, 0);
    tick = 1'b1;
    repeat (100) step();
    tick = 1'b0;
    hit(5);
    chk("hit_clock", sc_clock, 100);
    chk("hit_note", sc_note, 5);
    chk("eval_done", done, 0);
    step();
    chk("one_total", total_score, 501000);
    chk("one_cnt", sc_now_cnt, 1);
    chk("one_combo", sc_last_combo, 2);
    chk("one_base", sc_last_base_score, 500000);
    chk("one_max", max_combo, 2);
    chk("one_done", done, 1);
    chk("one_busy", busy, 0);
    // timeout: difficulty 4 gives window 176, goal 50 -> expires at 226
    sc_base_score = 0; sc_bonus_score = 0; sc_combo = 0; sc_level = 3'd2;
    run_start(2'b00, 4'd4);
    load_note(50, 3, 1'b1);
    tick = 1'b1;
    for (int i = 0; i < 400 && !done; i++) step();
    tick = 1'b0;
    chk("to_done", done, 1);
    chk("to_clock", sc_clock, 226);
    chk("to_note", sc_note, 4'hC);
    chk("to_total", total_score, 0);
    chk("to_cnt", sc_now_cnt, 1);
    chk("to_level", level_out, 2);
    chk("to_failed", failed, 0);
    // eight consecutive misses fail a normal run
    run_start(2'b00, 4'd15);
    chart_valid = 1'b1; chart_time = 0; chart_note = 3; chart_last = 1'b0; tick = 1'b1;
    for (int i = 0; i < 1000 && !failed; i++) step();
    chk("fail_flag", failed, 1);
    chk("fail_cnt", sc_now_cnt, 8);
    chk("fail_busy", busy, 0);
    step();
    step();
    chk("fail_ready", chart_ready, 0);
    chk("fail_hold", failed, 1);
    // No Fail mod survives long miss streaks
    run_start(2'b01, 4'd15);
    for (int i = 0; i < 2000 && !failed && sc_now_cnt != 12; i++) step();
    chk("nf_cnt", sc_now_cnt, 12);
    chk("nf_failed", failed, 0);
    chart_last = 1'b1;
    for (int i = 0; i < 20 && !done && !failed; i++) step();
    chart_valid = 1'b0; chart_last = 1'b0; tick = 1'b0;
    chk("nf_done", done, 1);
    chk("nf_cnt_last", sc_now_cnt, 13);
    chk("nf_failed_end", failed, 0);
    // early hit dropped, then hit coincident with timeout wins
    sc_base_score = 1000; sc_combo = 1; sc_level = 3'd3;
    run_start(2'b00, 4'd0);
    load_note(300, 7, 1'b1);
    tick = 1'b1;
    repeat (100) step();
    tick = 1'b0;
    hit(2);
    step();
    chk("early_busy", busy, 1);
    chk("early_done", done, 0);
    tick = 1'b1;
    repeat (388) step();
    tick = 1'b0;
    hit(9);
    chk("arb_note", sc_note, 9);
    chk("arb_clock", sc_clock, 488);
    step();
    chk("arb_done", done, 1);
    chk("arb_total", total_score, 1000);
    chk("arb_level", level_out, 3);
    // reset during EVAL discards the commit
    sc_base_score = 777; sc_bonus_score = 5;
    run_start(2'b00, 4'd0);
    load_note(10, 1, 1'b1);
    hit(1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_total", total_score, 0);
    chk("mid_rst_cnt", sc_now_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_level", level_out, 1);
    step();
    chk("idle_busy", busy, 0);
    chk("idle_total", total_score, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
